uart_rx_ctrl: RTL and testbench

Controller that sequences the uart_receive datapath and exposes it to the CPU-side register bus. It acknowledges each received byte (i_ctrl_done handshake) and buffers bytes in a FIFO. It tracks frame errors and overruns, owns the baud divisor (clk_div) with safe deferred update, and raises a level interrupt.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared constants and types for the UART receive controller:
//             register map, STATUS/CTRL bit positions, divisor floor and
//             ack FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register map
    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_CLKDIV = 2'd2;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int c_ST_NONEMPTY = 0;
    localparam int c_ST_FULL     = 1;
    localparam int c_ST_OVR      = 2;
    localparam int c_ST_FERR     = 3;
    localparam int c_ST_FCNT_CLR = 4;
    localparam int c_ST_FILL_LSB = 8;
    localparam int c_ST_FCNT_LSB = 16;

    // CTRL bit positions
    localparam int c_CTRL_RX_EN   = 0;
    localparam int c_CTRL_IRQ_EN  = 1;
    localparam int c_CTRL_THR_LSB = 8;

    // Smallest divisor the receiver can work with
    localparam logic [31:0] c_CLK_DIV_MIN = 32'd2;

    // Ack FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Synchronous byte FIFO for received data. A push while full is
//             accepted only when a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage array; the head is read combinationally so it stays valid while being overwritten
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Sequences the UART receive datapath: acknowledges each byte,
//             buffers it in a FIFO, tracks overrun / frame errors, owns the
//             baud divisor with deferred update and raises a level IRQ.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] CLK_DIV_RST = 32'd434,
    parameter logic [7:0]  THR_RST     = 8'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done_i,
    input  logic [7:0]  rx_data_i,
    input  logic        frame_err_i,
    input  logic        rx_busy_i,
    output logic        ctrl_done_o,
    output logic [31:0] clk_div_o,
    input  logic        reg_req_i,
    input  logic        reg_we_i,
    input  logic [1:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic        reg_ack_o,
    output logic        irq_o
);

    import uart_pkg::*;

    localparam int c_CW = $clog2(DEPTH) + 1;

    ack_state_t      r_state;
    ack_state_t      w_state_nxt;
    logic            w_accept;
    logic            w_ctrl_done;

    logic            r_rx_en;
    logic            r_irq_en;
    logic [7:0]      r_thr;
    logic            r_ovr;
    logic            r_ferr;
    logic [7:0]      r_fcnt;
    logic [31:0]     r_clk_div;
    logic [31:0]     r_div_stage;
    logic            r_div_pend;
    logic            r_ack;
    logic [31:0]     r_rdata;
    logic            r_irq;

    logic            w_rd;
    logic            w_wr;
    logic            w_data_rd;
    logic            w_status_wr;
    logic            w_clkdiv_wr;
    logic            w_ctrl_wr;
    logic            w_push;
    logic            w_ovr_set;
    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [c_CW-1:0] w_count;
    logic [7:0]      w_count8;
    logic [7:0]      w_thr_eff;
    logic [31:0]     w_div_clamped;
    logic [31:0]     w_status;
    logic [31:0]     w_rdata;

    // Register bus decode
    assign w_rd        = reg_req_i & ~reg_we_i;
    assign w_wr        = reg_req_i &  reg_we_i;
    assign w_data_rd   = w_rd & (reg_addr_i == c_ADDR_DATA);
    assign w_status_wr = w_wr & (reg_addr_i == c_ADDR_STATUS);
    assign w_clkdiv_wr = w_wr & (reg_addr_i == c_ADDR_CLKDIV);
    assign w_ctrl_wr   = w_wr & (reg_addr_i == c_ADDR_CTRL);

    // A full FIFO only overruns if no DATA read frees a slot this cycle
    assign w_push    = w_accept & r_rx_en;
    assign w_ovr_set = w_push & w_full & ~w_data_rd;

    assign w_count8      = 8'(w_count);
    assign w_thr_eff     = (r_thr == 8'd0) ? 8'd1 : r_thr;
    assign w_div_clamped = (reg_wdata_i < c_CLK_DIV_MIN) ? c_CLK_DIV_MIN : reg_wdata_i;

    uart_rx_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (rx_data_i),
        .i_pop   (w_data_rd),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Ack FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Ack FSM next state: accept a byte in IDLE, acknowledge for one cycle in ACK
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ctrl_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_done_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_ctrl_done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // STATUS word assembly
    always_comb begin
        w_status                           = '0;
        w_status[c_ST_NONEMPTY]            = ~w_empty;
        w_status[c_ST_FULL]                = w_full;
        w_status[c_ST_OVR]                 = r_ovr;
        w_status[c_ST_FERR]                = r_ferr;
        w_status[c_ST_FILL_LSB +: 8]       = w_count8;
        w_status[c_ST_FCNT_LSB +: 8]       = r_fcnt;
    end

    // Read data mux
    always_comb begin
        w_rdata = '0;
        case (reg_addr_i)
            c_ADDR_DATA:   if (!w_empty) w_rdata = {23'd0, 1'b1, w_head};
            c_ADDR_STATUS: w_rdata = w_status;
            c_ADDR_CLKDIV: w_rdata = r_div_pend ? r_div_stage : r_clk_div;
            default: begin
                w_rdata[c_CTRL_RX_EN]         = r_rx_en;
                w_rdata[c_CTRL_IRQ_EN]        = r_irq_en;
                w_rdata[c_CTRL_THR_LSB +: 8]  = r_thr;
            end
        endcase
    end

    // Bus response: one-cycle ack, data presented only for reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= reg_req_i;
            r_rdata <= w_rd ? w_rdata : '0;
        end
    end

    // Sticky error flags and saturating frame counter; a new event beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_fcnt <= 8'd0;
        end else begin
            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (w_status_wr && reg_wdata_i[c_ST_OVR])
                r_ovr <= 1'b0;

            if (frame_err_i)
                r_ferr <= 1'b1;
            else if (w_status_wr && reg_wdata_i[c_ST_FERR])
                r_ferr <= 1'b0;

            if (w_status_wr && reg_wdata_i[c_ST_FCNT_CLR])
                r_fcnt <= frame_err_i ? 8'd1 : 8'd0;
            else if (frame_err_i && (r_fcnt != 8'hFF))
                r_fcnt <= r_fcnt + 8'd1;
        end
    end

    // CTRL register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_en  <= 1'b1;
            r_irq_en <= 1'b0;
            r_thr    <= THR_RST;
        end else if (w_ctrl_wr) begin
            r_rx_en  <= reg_wdata_i[c_CTRL_RX_EN];
            r_irq_en <= reg_wdata_i[c_CTRL_IRQ_EN];
            r_thr    <= reg_wdata_i[c_CTRL_THR_LSB +: 8];
        end
    end

    // Divisor staging: apply only while the receiver is quiet and no ack is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_div   <= CLK_DIV_RST;
            r_div_stage <= CLK_DIV_RST;
            r_div_pend  <= 1'b0;
        end else begin
            if (r_div_pend && !rx_busy_i && (r_state == ST_IDLE)) begin
                r_clk_div  <= r_div_stage;
                r_div_pend <= 1'b0;
            end
            if (w_clkdiv_wr) begin
                r_div_stage <= w_div_clamped;
                r_div_pend  <= 1'b1;
            end
        end
    end

    // Level interrupt from fill threshold or sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= r_irq_en & ((w_count8 >= w_thr_eff) | r_ovr | r_ferr);
    end

    assign ctrl_done_o = w_ctrl_done;
    assign clk_div_o   = r_clk_div;
    assign reg_ack_o   = r_ack;
    assign reg_rdata_o = r_rdata;
    assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl with a byte-queue model
//             and a scoreboard of expected register read data.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int          DEPTH    = 16;
    localparam logic [1:0]  A_DATA   = 2'd0;
    localparam logic [1:0]  A_STATUS = 2'd1;
    localparam logic [1:0]  A_CLKDIV = 2'd2;
    localparam logic [1:0]  A_CTRL   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_done_i;
    logic [7:0]  rx_data_i;
    logic        frame_err_i;
    logic        rx_busy_i;
    logic        ctrl_done_o;
    logic [31:0] clk_div_o;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [1:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        reg_ack_o;
    logic        irq_o;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DEPTH       (DEPTH),
        .CLK_DIV_RST (32'd434),
        .THR_RST     (8'd1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_done_i   (rx_done_i),
        .rx_data_i   (rx_data_i),
        .frame_err_i (frame_err_i),
        .rx_busy_i   (rx_busy_i),
        .ctrl_done_o (ctrl_done_o),
        .clk_div_o   (clk_div_o),
        .reg_req_i   (reg_req_i),
        .reg_we_i    (reg_we_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ack_o   (reg_ack_o),
        .irq_o       (irq_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_cur;

    typedef struct {
        bit          we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_rx_en;
    bit         m_irq_en;
    logic [7:0] m_thr;
    bit         m_ovr;
    bit         m_ferr;
    logic [7:0] m_fcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_q.size() != 0);
        s[1]     = (m_q.size() == DEPTH);
        s[2]     = m_ovr;
        s[3]     = m_ferr;
        s[15:8]  = 8'(m_q.size());
        s[23:16] = m_fcnt;
        return s;
    endfunction

    function automatic logic m_irq();
        int thr;
        thr = (m_thr == 8'd0) ? 1 : int'(m_thr);
        return m_irq_en & ((m_q.size() >= thr) | m_ovr | m_ferr);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rx_en  = 1'b1;
        m_irq_en = 1'b0;
        m_thr    = 8'd1;
        m_ovr    = 1'b0;
        m_ferr   = 1'b0;
        m_fcnt   = 8'd0;
    endtask

    // Scoreboard consumer: every ack pops one expectation
    always @(negedge clk) begin
        if (rst_n && reg_ack_o) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with rdata %h expected no ack", reg_rdata_o);
            end else begin
                sb_cur = sb_q.pop_front();
                if (sb_cur.chk) check(sb_cur.name, reg_rdata_o, sb_cur.exp);
            end
        end
    end

    task automatic reg_op(input bit we, input logic [1:0] addr, input logic [31:0] wd,
                          input bit chk, input logic [31:0] exp, input string name);
        sb_t e;
        e.chk  = chk & ~we;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wd;
        @(negedge clk);
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
    endtask

    task automatic read_data(input string name);
        logic [31:0] e;
        e = '0;
        if (m_q.size() > 0) e = {23'd0, 1'b1, m_q.pop_front()};
        reg_op(1'b0, A_DATA, 32'd0, 1'b1, e, name);
    endtask

    task automatic read_status(input string name);
        reg_op(1'b0, A_STATUS, 32'd0, 1'b1, m_status(), name);
    endtask

    task automatic write_status(input logic [31:0] wd);
        reg_op(1'b1, A_STATUS, wd, 1'b0, 32'd0, "wr_status");
        if (wd[2]) m_ovr  = 1'b0;
        if (wd[3]) m_ferr = 1'b0;
        if (wd[4]) m_fcnt = 8'd0;
    endtask

    task automatic write_ctrl(input logic [31:0] wd);
        reg_op(1'b1, A_CTRL, wd, 1'b0, 32'd0, "wr_ctrl");
        m_rx_en  = wd[0];
        m_irq_en = wd[1];
        m_thr    = wd[15:8];
    endtask

    task automatic check_irq(input string name);
        @(negedge clk);
        check(name, irq_o, m_irq());
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done_i = 1'b1;
        rx_data_i = b;
        if (m_rx_en) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else                    m_ovr = 1'b1;
        end
        @(negedge clk);
        rx_done_i = 1'b0;
        check("ctrl_done_hi", ctrl_done_o, 1);
        @(negedge clk);
        check("ctrl_done_lo", ctrl_done_o, 0);
    endtask

    // Received byte and a register access landing in the same cycle
    task automatic rx_and_reg(input logic [7:0] b, input bit we, input logic [1:0] addr,
                              input logic [31:0] wd, input string name);
        sb_t e;
        bit  set_ovr;
        set_ovr = 1'b0;
        e.chk   = !we && (addr == A_DATA || addr == A_STATUS);
        e.exp   = '0;
        e.name  = name;
        if (!we && addr == A_STATUS) e.exp = m_status();
        if (!we && addr == A_DATA && m_q.size() > 0) e.exp = {23'd0, 1'b1, m_q.pop_front()};
        if (m_rx_en) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else                    set_ovr = 1'b1;
        end
        if (we && addr == A_STATUS) begin
            if (wd[2]) m_ovr  = 1'b0;
            if (wd[3]) m_ferr = 1'b0;
            if (wd[4]) m_fcnt = 8'd0;
        end
        if (set_ovr) m_ovr = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        rx_done_i   = 1'b1;
        rx_data_i   = b;
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wd;
        @(negedge clk);
        rx_done_i   = 1'b0;
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        check("sim_ctrl_done_hi", ctrl_done_o, 1);
        @(negedge clk);
        check("sim_ctrl_done_lo", ctrl_done_o, 0);
    endtask

    task automatic pulse_ferr();
        @(negedge clk);
        frame_err_i = 1'b1;
        m_ferr      = 1'b1;
        if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
        @(negedge clk);
        frame_err_i = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        rx_done_i   = 1'b0;
        rx_data_i   = 8'd0;
        frame_err_i = 1'b0;
        rx_busy_i   = 1'b0;
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = 2'd0;
        reg_wdata_i = 32'd0;
        model_reset();

        vecs[0]  = '{we: 1'b0, addr: A_STATUS, wd: 32'd0,        exp: 32'h0000_0000};
        vecs[1]  = '{we: 1'b0, addr: A_CTRL,   wd: 32'd0,        exp: 32'h0000_0101};
        vecs[2]  = '{we: 1'b0, addr: A_CLKDIV, wd: 32'd0,        exp: 32'd434};
        vecs[3]  = '{we: 1'b0, addr: A_DATA,   wd: 32'd0,        exp: 32'h0000_0000};
        vecs[4]  = '{we: 1'b1, addr: A_DATA,   wd: 32'h55,       exp: 32'd0};
        vecs[5]  = '{we: 1'b0, addr: A_STATUS, wd: 32'd0,        exp: 32'h0000_0000};
        vecs[6]  = '{we: 1'b1, addr: A_CTRL,   wd: 32'h0000_0000, exp: 32'd0};
        vecs[7]  = '{we: 1'b0, addr: A_CTRL,   wd: 32'd0,        exp: 32'h0000_0000};
        vecs[8]  = '{we: 1'b1, addr: A_CTRL,   wd: 32'h0000_FF02, exp: 32'd0};
        vecs[9]  = '{we: 1'b0, addr: A_CTRL,   wd: 32'd0,        exp: 32'h0000_FF02};
        vecs[10] = '{we: 1'b1, addr: A_CTRL,   wd: 32'h0000_0101, exp: 32'd0};
        vecs[11] = '{we: 1'b0, addr: A_CTRL,   wd: 32'd0,        exp: 32'h0000_0101};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_clk_div", clk_div_o, 32'd434);
        check("rst_irq", irq_o, 0);
        check("rst_ctrl_done", ctrl_done_o, 0);
        check("rst_ack", reg_ack_o, 0);
        check("rst_rdata", reg_rdata_o, 0);
        rst_n = 1'b1;

        // Register table
        for (int i = 0; i < 12; i++) begin
            reg_op(vecs[i].we, vecs[i].addr, vecs[i].wd, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Single byte
        rx_byte(8'hA5);
        read_status("a5_status");
        read_data("a5_data");
        read_status("a5_status_after");

        // Overrun: 17 bytes without reads
        for (int i = 0; i <= 16; i++) rx_byte(8'(i));
        read_status("ovr_status");
        for (int i = 0; i < 16; i++) read_data($sformatf("ovr_data%0d", i));
        write_status(32'h4);
        read_status("ovr_cleared");

        // Overrun set against simultaneous W1C: set wins
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h40 + i));
        rx_and_reg(8'h99, 1'b1, A_STATUS, 32'h4, "ovr_setwins_wr");
        read_status("ovr_setwins");
        for (int i = 0; i < 16; i++) read_data($sformatf("refill_data%0d", i));
        write_status(32'h4);
        read_status("refill_empty");

        // Threshold interrupt
        write_ctrl(32'h0000_0303);
        check_irq("irq_empty");
        rx_byte(8'h11);
        rx_byte(8'h22);
        check_irq("irq_two");
        rx_byte(8'h33);
        check_irq("irq_three");
        pulse_ferr();
        read_status("ferr_status");
        for (int i = 0; i < 3; i++) read_data($sformatf("irq_data%0d", i));
        check_irq("irq_ferr_hold");
        write_status(32'h8);
        check_irq("irq_ferr_clr");

        // Threshold zero behaves as one
        write_ctrl(32'h0000_0003);
        check_irq("irq_thr0_empty");
        rx_byte(8'h5A);
        check_irq("irq_thr0_one");
        read_data("thr0_data");
        check_irq("irq_thr0_drained");

        // Frame error against simultaneous W1C: set wins
        @(negedge clk);
        begin
            sb_t e;
            e.chk = 1'b0; e.exp = '0; e.name = "ferr_w1c";
            sb_q.push_back(e);
        end
        frame_err_i = 1'b1;
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = A_STATUS; reg_wdata_i = 32'h8;
        m_ferr = 1'b1;
        m_fcnt = m_fcnt + 8'd1;
        @(negedge clk);
        frame_err_i = 1'b0;
        reg_req_i = 1'b0; reg_we_i = 1'b0;
        read_status("ferr_setwins");
        check_irq("irq_ferr_setwins");

        // Frame counter clear and saturation
        write_status(32'h18);
        read_status("fcnt_cleared");
        for (int i = 0; i < 260; i++) pulse_ferr();
        read_status("fcnt_sat");
        write_status(32'h18);
        read_status("fcnt_sat_cleared");
        write_ctrl(32'h0000_0101);

        // Deferred divisor update
        rx_busy_i = 1'b1;
        reg_op(1'b1, A_CLKDIV, 32'h56, 1'b0, 32'd0, "wr_div");
        repeat (2) @(negedge clk);
        check("div_held", clk_div_o, 32'd434);
        reg_op(1'b0, A_CLKDIV, 32'd0, 1'b1, 32'h56, "div_staged");
        rx_busy_i = 1'b0;
        @(negedge clk);
        check("div_applied", clk_div_o, 32'h56);
        reg_op(1'b0, A_CLKDIV, 32'd0, 1'b1, 32'h56, "div_live");
        rx_busy_i = 1'b1;
        reg_op(1'b1, A_CLKDIV, 32'h1, 1'b0, 32'd0, "wr_div1");
        reg_op(1'b0, A_CLKDIV, 32'd0, 1'b1, 32'h2, "div_clamp1");
        reg_op(1'b1, A_CLKDIV, 32'h77, 1'b0, 32'd0, "wr_div77");
        reg_op(1'b0, A_CLKDIV, 32'd0, 1'b1, 32'h77, "div_overwrite");
        reg_op(1'b1, A_CLKDIV, 32'h0, 1'b0, 32'd0, "wr_div0");
        reg_op(1'b0, A_CLKDIV, 32'd0, 1'b1, 32'h2, "div_clamp0");
        check("div_still_held", clk_div_o, 32'h56);
        rx_busy_i = 1'b0;
        repeat (2) @(negedge clk);
        check("div_applied2", clk_div_o, 32'h2);

        // Push and pop in the same cycle
        rx_byte(8'h31);
        rx_byte(8'h32);
        rx_byte(8'h33);
        rx_and_reg(8'h77, 1'b0, A_DATA, 32'd0, "simul_pop");
        read_status("simul_count");
        for (int i = 0; i < 3; i++) read_data($sformatf("simul_data%0d", i));
        rx_and_reg(8'h44, 1'b0, A_DATA, 32'd0, "simul_empty");
        read_data("simul_empty_data");
        for (int i = 0; i < 16; i++) rx_byte(8'(8'hC0 + i));
        rx_and_reg(8'h88, 1'b0, A_DATA, 32'd0, "simul_full");
        read_status("simul_full_status");
        for (int i = 0; i < 16; i++) read_data($sformatf("full_drain%0d", i));

        // Receive disabled: ack still issued, byte dropped
        rx_byte(8'h10);
        write_ctrl(32'h0000_0100);
        rx_byte(8'h66);
        read_status("rxdis_status");
        write_ctrl(32'h0000_0101);
        read_data("rxdis_data");

        // Asynchronous reset during an ack with a divisor staged
        rx_busy_i = 1'b1;
        reg_op(1'b1, A_CLKDIV, 32'h99, 1'b0, 32'd0, "wr_div99");
        rx_byte(8'h21);
        @(negedge clk);
        rx_done_i = 1'b1;
        rx_data_i = 8'h22;
        @(posedge clk);
        #1;
        rx_done_i = 1'b0;
        check("pre_rst_ctrl_done", ctrl_done_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl_done", ctrl_done_o, 0);
        check("mid_rst_clk_div", clk_div_o, 32'd434);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        rx_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_clk_div", clk_div_o, 32'd434);
        read_status("post_rst_status");
        reg_op(1'b0, A_CLKDIV, 32'd0, 1'b1, 32'd434, "post_rst_div");
        reg_op(1'b0, A_CTRL, 32'd0, 1'b1, 32'h0000_0101, "post_rst_ctrl");

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
